// File: rtl/maxpool_2x2_stream_if.sv
// Pixel-stream bundle for the 2x2 max-pool stage: input pixels in, pooled values out.
interface maxpool_2x2_stream_if #(
   parameter int unsigned Datawidth = 16
);
   logic [Datawidth-1:0] In;
   logic                 Valid_IN;
   logic [Datawidth-1:0] Out;
   logic                 Valid_OUT;
   logic                 Frame_Done;

   modport master (
      output In, Valid_IN,
      input  Out, Valid_OUT, Frame_Done
   );

   modport slave (
      input  In, Valid_IN,
      output Out, Valid_OUT, Frame_Done
   );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster pixel stream.
// Even rows park pair maxima in a half-width line buffer; odd rows finish each window.
module maxpool_2x2_stream #(
   parameter int unsigned IMG_Width  = 4,
   parameter int unsigned IMG_Height = 4,
   parameter int unsigned Datawidth  = 16
) (
   input logic                 CLK,
   input logic                 CLR,
   maxpool_2x2_stream_if.slave bus
);

   localparam int unsigned ColW    = $clog2(IMG_Width);
   localparam int unsigned RowW    = $clog2(IMG_Height);
   // Padded to two entries so a 2-wide map still gets a non-degenerate index.
   localparam int unsigned LbDepth = (IMG_Width / 2 < 2) ? 2 : IMG_Width / 2;
   localparam int unsigned LbAw    = $clog2(LbDepth);

   logic [ColW-1:0]             col_q, col_d;
   logic [RowW-1:0]             row_q, row_d;
   logic signed [Datawidth-1:0] hold_q, hold_d;
   logic signed [Datawidth-1:0] out_q, out_d;
   logic                        valid_q, valid_d;
   logic                        done_q, done_d;
   logic signed [Datawidth-1:0] lb_q [LbDepth];

   logic signed [Datawidth-1:0] pix;
   logic signed [Datawidth-1:0] pair_max;
   logic signed [Datawidth-1:0] lb_rd;
   logic [LbAw-1:0]             lb_idx;
   logic                        lb_we;
   logic                        col_last;
   logic                        row_last;

   assign pix      = bus.In;
   assign lb_idx   = LbAw'(col_q >> 1);
   assign lb_rd    = lb_q[lb_idx];
   assign pair_max = (hold_q > pix) ? hold_q : pix;
   assign col_last = (col_q == ColW'(IMG_Width - 1));
   assign row_last = (row_q == RowW'(IMG_Height - 1));

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      hold_d  = hold_q;
      out_d   = out_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      lb_we   = 1'b0;
      if (bus.Valid_IN) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (!col_q[0]) begin
            hold_d = pix;
         end else if (!row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            out_d   = (lb_rd > pair_max) ? lb_rd : pair_max;
            valid_d = 1'b1;
            done_d  = col_last && row_last;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         col_q   <= '0;
         row_q   <= '0;
         hold_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         hold_q  <= hold_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Every entry is rewritten in an even row before its odd-row read, so no reset.
   always_ff @(posedge CLK) begin
      if (!CLR && lb_we) begin
         lb_q[lb_idx] <= pair_max;
      end
   end

   assign bus.Out        = out_q;
   assign bus.Valid_OUT  = valid_q;
   assign bus.Frame_Done = done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Table-driven bench for maxpool_2x2_stream: three map geometries, scoreboard on outputs.
module tb_maxpool_2x2_stream;

   typedef struct {
      int          sel;
      bit          clr;
      bit          vld;
      logic [15:0] pix;
      bit          en;
      logic [15:0] exp;
      bit          done;
   } vec_t;

   typedef struct {
      int          sel;
      logic [15:0] val;
      bit          done;
      int          due;
   } exp_t;

   logic CLK = 1'b0;
   logic CLR = 1'b1;

   maxpool_2x2_stream_if #(.Datawidth(16)) bus4 ();
   maxpool_2x2_stream_if #(.Datawidth(16)) bus2 ();
   maxpool_2x2_stream_if #(.Datawidth(16)) bus6 ();

   maxpool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16)) u_dut4 (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus4)
   );

   maxpool_2x2_stream #(.IMG_Width(2), .IMG_Height(2), .Datawidth(16)) u_dut2 (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus2)
   );

   maxpool_2x2_stream #(.IMG_Width(6), .IMG_Height(2), .Datawidth(16)) u_dut6 (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus6)
   );

   always #5 CLK = ~CLK;

   int   checks   = 0;
   int   failures = 0;
   int   neg_cnt  = 0;
   bit   mon_en   = 1'b0;
   exp_t sb[$];
   vec_t vecs[$];
   logic [15:0] last_exp [3];

   logic        vo [3];
   logic        dn [3];
   logic [15:0] oo [3];
   assign vo[0] = bus4.Valid_OUT;
   assign vo[1] = bus2.Valid_OUT;
   assign vo[2] = bus6.Valid_OUT;
   assign dn[0] = bus4.Frame_Done;
   assign dn[1] = bus2.Frame_Done;
   assign dn[2] = bus6.Frame_Done;
   assign oo[0] = bus4.Out;
   assign oo[1] = bus2.Out;
   assign oo[2] = bus6.Out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input int sel, input bit clr, input bit vld, input logic [15:0] pix,
                               input bit en, input logic [15:0] exp, input bit done);
      vec_t v;
      v.sel  = sel;
      v.clr  = clr;
      v.vld  = vld;
      v.pix  = pix;
      v.en   = en;
      v.exp  = exp;
      v.done = done;
      return v;
   endfunction

   // 4x4 raster frame base..base+15; window maxima sit at pixels 5, 7, 13, 15.
   task automatic add_frame4(input int base, input int gaps);
      for (int p = 0; p < 16; p++) begin
         bit en;
         en = (p == 5) || (p == 7) || (p == 13) || (p == 15);
         vecs.push_back(mk(0, 1'b0, 1'b1, 16'(base + p), en, 16'(base + p), p == 15));
         for (int g = 0; g < gaps; g++) vecs.push_back(mk(0, 1'b0, 1'b0, 16'hDEAD, 1'b0, 16'h0, 1'b0));
      end
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      @(posedge CLK);
      #1;
      CLR           = v.clr;
      bus4.Valid_IN = 1'b0;
      bus2.Valid_IN = 1'b0;
      bus6.Valid_IN = 1'b0;
      case (v.sel)
         0: begin bus4.Valid_IN = v.vld; bus4.In = v.pix; end
         1: begin bus2.Valid_IN = v.vld; bus2.In = v.pix; end
         default: begin bus6.Valid_IN = v.vld; bus6.In = v.pix; end
      endcase
      if (v.en && v.vld && !v.clr) begin
         e.sel  = v.sel;
         e.val  = v.exp;
         e.done = v.done;
         e.due  = neg_cnt + 2;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(posedge CLK);
      #1;
      CLR           = 1'b0;
      bus4.Valid_IN = 1'b0;
      bus2.Valid_IN = 1'b0;
      bus6.Valid_IN = 1'b0;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      neg_cnt++;
      if (mon_en) begin
         for (int s = 0; s < 3; s++) begin
            if (vo[s] === 1'b1) begin
               if (sb.size() == 0) begin
                  check($sformatf("spurious_valid_dut%0d", s), 1, 0);
               end else if (sb[0].sel != s) begin
                  check($sformatf("wrong_dut_valid_dut%0d", s), s, sb[0].sel);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("out_dut%0d", s), oo[s], e.val);
                  check($sformatf("frame_done_dut%0d", s), dn[s], e.done);
                  check($sformatf("latency_dut%0d", s), neg_cnt, e.due);
                  last_exp[s] = e.val;
               end
            end else begin
               check($sformatf("done_without_valid_dut%0d", s), dn[s], 0);
               check($sformatf("out_hold_dut%0d", s), oo[s], last_exp[s]);
            end
         end
      end
      if (CLR) begin
         for (int s = 0; s < 3; s++) last_exp[s] = 16'h0;
      end
   end

   initial begin
      bus4.Valid_IN = 1'b0; bus4.In = '0;
      bus2.Valid_IN = 1'b0; bus2.In = '0;
      bus6.Valid_IN = 1'b0; bus6.In = '0;
      for (int s = 0; s < 3; s++) last_exp[s] = 16'h0;

      // Stimulus table
      add_frame4(0, 0);
      add_frame4(0, 2);
      add_frame4(0, 0);
      add_frame4(100, 0);
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'hFFFD, 1'b0, 16'h0000, 1'b0));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'hFFF9, 1'b0, 16'h0000, 1'b0));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'hFFFF, 1'b1));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'h8000, 1'b0, 16'h0000, 1'b0));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'h7FFF, 1'b0, 16'h0000, 1'b0));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0));
      vecs.push_back(mk(1, 1'b0, 1'b1, 16'h8001, 1'b1, 16'h7FFF, 1'b1));
      for (int p = 0; p < 12; p++) begin
         bit en;
         en = (p == 7) || (p == 9) || (p == 11);
         vecs.push_back(mk(2, 1'b0, 1'b1, 16'(p), en, 16'(p), p == 11));
      end

      repeat (3) @(posedge CLK);
      #1;
      CLR = 1'b0;
      @(negedge CLK);
      check("reset_valid_dut4", bus4.Valid_OUT, 0);
      check("reset_done_dut4", bus4.Frame_Done, 0);
      check("reset_out_dut4", bus4.Out, 0);
      check("reset_valid_dut2", bus2.Valid_OUT, 0);
      check("reset_out_dut2", bus2.Out, 0);
      check("reset_valid_dut6", bus6.Valid_OUT, 0);
      check("reset_out_dut6", bus6.Out, 0);
      mon_en = 1'b1;

      for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
      repeat (3) idle();

      // Mid-frame reset: six pixels, a CLR cycle carrying a pixel that must be dropped, fresh frame.
      for (int p = 0; p < 6; p++) drive(mk(0, 1'b0, 1'b1, 16'(p), p == 5, 16'(p), 1'b0));
      drive(mk(0, 1'b1, 1'b1, 16'd99, 1'b0, 16'h0, 1'b0));
      idle();
      @(negedge CLK);
      check("post_clr_valid", bus4.Valid_OUT, 0);
      check("post_clr_done", bus4.Frame_Done, 0);
      check("post_clr_out", bus4.Out, 0);
      vecs.delete();
      add_frame4(0, 0);
      for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
      idle();

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
      check("scoreboard_drained", sb.size(), 0);
      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/maxpool_2x2_stream.md
# maxpool_2x2_stream

Streaming 2×2, stride-2 max-pooling stage placed directly downstream of the 1×1 convolution stage. It consumes that stage's raster-ordered pixel stream (data plus valid strobe) for one IMG_Width×IMG_Height feature map, one pixel per accepted cycle. It emits one pooled value per 2×2 window, (IMG_Width/2)×(IMG_Height/2) values per frame, in raster order. A single half-width line buffer holds the partial maxima of the even rows.

## Interface
Parameters:
- IMG_Width, 4: input map width in pixels; must be even and ≥2.
- IMG_Height, 4: input map height in pixels; must be even and ≥2.
- Datawidth, 16: pixel width, two's-complement signed.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  synchronous, active-high reset.
- In  in  Datawidth  input pixel, sampled when Valid_IN=1.
- Valid_IN  in  1  input strobe; one pixel accepted per cycle it is high.
- Out  out  Datawidth  pooled maximum.
- Valid_OUT  out  1  one-cycle pulse per pooled value.
- Frame_Done  out  1  one-cycle pulse coincident with the last Valid_OUT of a frame.

## Operation
- Position counters: col (0..IMG_Width-1) and row (0..IMG_Height-1).
  - Both advance only on accepted pixels.
  - col wraps to 0 and increments row.
  - After (row=H-1, col=W-1), both wrap to 0 and the next accepted pixel starts a new frame. There is no idle state between frames.
- Horizontal stage:
  - Even col: store In in hold register H.
  - Odd col: form the pair maximum m = max(H, In).
- Vertical stage:
  - Even row, odd col: write m into line buffer LB[col>>1]. LB depth is IMG_Width/2.
  - Odd row, odd col: Out <= max(LB[col>>1], m) and Valid_OUT <= 1.
  - Same case, when also row=H-1 and col=W-1: Frame_Done <= 1.
- Comparison is signed two's-complement over the full Datawidth. Ties produce the equal value. No truncation or widening.
- Every LB entry is written in an even row before it is read in the following odd row. LB therefore needs no reset.
- Out holds its last value while Valid_OUT=0.
- The stage applies no back-pressure. The upstream stage may insert arbitrary gaps (Valid_IN=0 cycles); gaps freeze all state.

## Timing
- Reset values: Valid_OUT=0, Frame_Done=0, Out=0, col=0, row=0, H=0.
- CLR has priority over Valid_IN. A pixel presented in a CLR cycle is dropped.
- Reset mid-frame discards the partial frame. The first accepted pixel after CLR deasserts is position (0,0).
- Latency: Valid_OUT rises exactly 1 cycle after the cycle that accepts the pixel at (odd row, odd col). It stays high for 1 cycle unless the next output-producing pixel is accepted in the following cycle. This cannot happen for W≥2, so Valid_OUT is never high on consecutive cycles.
- With continuous input, an odd row produces outputs on every second cycle. Even rows produce no output.
- Frame_Done pulses once per frame, in the same cycle as the (W/2)·(H/2)-th Valid_OUT.
- Throughput: one input pixel per cycle sustained, including across frame boundaries.

## Test plan
- W=H=4, continuous Valid_IN, pixels 0..15 raster:
  - Outputs 5, 7, 13, 15, each appearing 1 cycle after accepting pixels 5, 7, 13 and 15 respectively.
  - Frame_Done pulses only with 15.
  - Exactly 4 Valid_OUT pulses.
- Signed compare, W=H=2:
  - Inputs 0xFFFD, 0xFFFF, 0xFFF9, 0xFFFE (−3, −1, −7, −2) → Out=0xFFFF.
  - Then 0x8000, 0x7FFF, 0x0000, 0x8001 → Out=0x7FFF.
- Gapped input:
  - Repeat the first scenario with Valid_IN following the pattern 1,0,0,1,0,….
  - Same 4 values required.
  - Each arrives 1 cycle after its accepting pulse.
  - No pulses during gaps; Out stable between pulses.
- Back-to-back frames: two W=H=4 frames with no gap, second frame = first +100.
  - Outputs 5, 7, 13, 15, 105, 107, 113, 115.
  - Frame_Done pulses twice.
- Reset mid-frame:
  - Accept 6 pixels, then assert CLR for 1 cycle while Valid_IN=1 with In=99.
  - Then send a full frame 0..15.
  - Required: 99 dropped; Valid_OUT/Frame_Done/Out read 0 in the cycle after CLR; outputs exactly 5, 7, 13, 15.
- Non-square, W=6, H=2, pixels 0..11:
  - Outputs 7, 9, 11 at 1 cycle after pixels 7, 9 and 11.
  - Frame_Done with 11.
